lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 142 ++++++++++++++
 tb/tb_lfsr_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Galois/Fibonacci LFSR with multi-step advance, runtime seed load,
// all-zero lock-up recovery and on-line period measurement.
module lfsr_gen #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned       MODE  = 0,
  parameter int unsigned       STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             out,
  output logic [STEPS-1:0] out_bits,
  output logic             valid,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH:0]   period
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   period_q, period_d;
  logic [STEPS-1:0] bits_q, bits_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] stepped;
  logic [STEPS-1:0] step_bits;
  logic             cnt_sat;

  // One shift of the register; result is {bit shifted out, next state}.
  function automatic logic [WIDTH:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic             b;
    logic [WIDTH-1:0] n;
    if (MODE == 0) begin
      b = s[0];
      n = s >> 1;
      if (b) begin
        n = n ^ TAPS;
      end
    end else begin
      b    = s[WIDTH-1];
      n    = s << 1;
      n[0] = ^(s & TAPS);
    end
    return {b, n};
  endfunction

  always_comb begin
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   r;
    s         = state_q;
    r         = '0;
    step_bits = '0;
    for (int k = 0; k < STEPS; k++) begin
      r            = lfsr_step(s);
      step_bits[k] = r[WIDTH];
      s            = r[WIDTH-1:0];
    end
    stepped = s;
  end

  assign cnt_sat = &cnt_q;

  // Priority: load, then lock-up recovery, then stepping.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    bits_d   = bits_q;
    valid_d  = 1'b0;
    lockup_d = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      if (seed_in == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_in;
      end
      ref_d = state_d;
      cnt_d = '0;
    end else if (state_q == '0) begin
      state_d  = SEED;
      ref_d    = SEED;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (en) begin
      state_d = stepped;
      bits_d  = step_bits;
      valid_d = 1'b1;
      if (stepped == ref_q) begin
        // A saturated count means the true period is unknown, so keep the old one.
        if (!cnt_sat) begin
          period_d = cnt_q + 1'b1;
          done_d   = 1'b1;
        end
        cnt_d = '0;
      end else if (!cnt_sat) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      bits_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bits_q   <= bits_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      done_q   <= done_d;
    end
  end

  assign state       = state_q;
  assign out_bits    = bits_q;
  assign out         = bits_q[STEPS-1];
  assign valid       = valid_q;
  assign lockup      = lockup_q;
  assign period_done = done_q;
  assign period      = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three 4-bit instances (Galois, Fibonacci, Galois x3 steps)
// driven by shared directed and random stimulus, checked against an arithmetic model.
module tb_lfsr_gen;

  localparam int W      = 4;
  localparam int MAXCNT = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] seed_in;

  logic [3:0] st0, st1, st2;
  logic [0:0] ob0, ob1;
  logic [2:0] ob2;
  logic       o0, o1, o2, v0, v1, v2, lk0, lk1, lk2, pd0, pd1, pd2;
  logic [4:0] per0, per1, per2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(0), .STEPS(1)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .state(st0), .out(o0),
    .out_bits(ob0), .valid(v0), .lockup(lk0), .period_done(pd0), .period(per0)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .MODE(1), .STEPS(1)) u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .state(st1), .out(o1),
    .out_bits(ob1), .valid(v1), .lockup(lk1), .period_done(pd1), .period(per1)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(0), .STEPS(3)) u_gal3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .state(st2), .out(o2),
    .out_bits(ob2), .valid(v2), .lockup(lk2), .period_done(pd2), .period(per2)
  );

  // Reference model, one entry per instance.
  int m_mode[3]  = '{0, 1, 0};
  int m_taps[3]  = '{12, 9, 12};
  int m_steps[3] = '{1, 1, 3};
  int m_st[3], m_ref[3], m_cnt[3], m_bits[3], m_per[3];
  int m_valid[3], m_lock[3], m_done[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 1; m_ref[i] = 1; m_cnt[i] = 0; m_bits[i] = 0; m_per[i] = 0;
      m_valid[i] = 0; m_lock[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_cycle();
    int s, b, v;
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0; m_lock[i] = 0; m_done[i] = 0;
      if (load) begin
        v = int'(seed_in);
        if (v == 0) begin v = 1; m_lock[i] = 1; end
        m_st[i] = v; m_ref[i] = v; m_cnt[i] = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1; m_ref[i] = 1; m_cnt[i] = 0; m_lock[i] = 1;
      end else if (en) begin
        s = m_st[i];
        m_bits[i] = 0;
        for (int k = 0; k < m_steps[i]; k++) begin
          if (m_mode[i] == 0) begin
            b = s % 2;
            s = s / 2;
            if (b == 1) s = s ^ m_taps[i];
          end else begin
            b = s / (1 << (W - 1));
            s = ((s * 2) % (1 << W)) + ($countones(s & m_taps[i]) % 2);
          end
          m_bits[i] += b << k;
        end
        m_st[i] = s;
        m_valid[i] = 1;
        if (s == m_ref[i]) begin
          if (m_cnt[i] != MAXCNT) begin m_per[i] = m_cnt[i] + 1; m_done[i] = 1; end
          m_cnt[i] = 0;
        end else if (m_cnt[i] != MAXCNT) begin
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] st, input logic [2:0] ob,
                            input logic o, input logic v, input logic lk, input logic pd,
                            input logic [4:0] per);
    string n;
    n = $sformatf("inst%0d", i);
    check({n, ".state"}, 32'(st), 32'(m_st[i]));
    check({n, ".out_bits"}, 32'(ob), 32'(m_bits[i]));
    check({n, ".out"}, 32'(o), 32'((m_bits[i] >> (m_steps[i] - 1)) & 1));
    check({n, ".valid"}, 32'(v), 32'(m_valid[i]));
    check({n, ".lockup"}, 32'(lk), 32'(m_lock[i]));
    check({n, ".period_done"}, 32'(pd), 32'(m_done[i]));
    check({n, ".period"}, 32'(per), 32'(m_per[i]));
  endtask

  task automatic check_all();
    check_inst(0, st0, {2'b00, ob0}, o0, v0, lk0, pd0, per0);
    check_inst(1, st1, {2'b00, ob1}, o1, v1, lk1, pd1, per1);
    check_inst(2, st2, ob2, o2, v2, lk2, pd2, per2);
  endtask

  task automatic tick();
    if (!rst) model_reset();
    else model_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  int gal_seq[15] = '{12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9, 8, 4, 2, 1};
  int gal_out[15] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; seed_in = 4'h0;
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // Full period with en held high.
    en = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      check($sformatf("gal_seq[%0d]", t), 32'(st0), 32'(gal_seq[t]));
      check($sformatf("gal_out[%0d]", t), 32'(o0), 32'(gal_out[t]));
      if (t == 0) begin
        check("gal3_first_state", 32'(st2), 32'h3);
        check("gal3_first_bits", 32'(ob2), 32'b001);
        check("gal3_first_valid", 32'(v2), 32'h1);
      end
    end
    check("gal_period_done", 32'(pd0), 32'h1);
    check("gal_period", 32'(per0), 32'd15);
    check("fib_period_done", 32'(pd1), 32'h1);
    check("fib_period", 32'(per1), 32'd15);

    // Random en pattern.
    for (int t = 0; t < 40; t++) begin
      en = 1'($urandom_range(0, 1));
      tick();
    end

    // Load wins over en; then a full period from the loaded seed.
    load = 1'b1; seed_in = 4'h6; en = 1'b1;
    tick();
    check("load6_state", 32'(st0), 32'h6);
    check("load6_valid", 32'(v0), 32'h0);
    load = 1'b0;
    for (int t = 0; t < 15; t++) tick();
    check("load6_period_done", 32'(pd0), 32'h1);
    check("load6_period", 32'(per0), 32'd15);

    // Zero seed is replaced and flagged for exactly one cycle.
    en = 1'b0; load = 1'b1; seed_in = 4'h0;
    tick();
    check("zero_load_state", 32'(st0), 32'h1);
    check("zero_load_lockup", 32'(lk0), 32'h1);
    check("zero_load_valid", 32'(v0), 32'h0);
    load = 1'b0;
    tick();
    check("zero_load_lockup_drop", 32'(lk0), 32'h0);

    // Random loads mixed with stepping.
    for (int t = 0; t < 40; t++) begin
      en      = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 7) == 0);
      seed_in = 4'($urandom_range(0, 15));
      tick();
    end
    load = 1'b0;

    // Asynchronous reset between edges.
    en = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_state", 32'(st0), 32'h1);
    check("async_rst_period", 32'(per0), 32'h0);
    check("async_rst_valid", 32'(v0), 32'h0);
    check_all();
    #1 rst = 1'b1;

    // Gated en must not disturb the period count.
    for (int t = 0; t < 7; t++) tick();
    en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("gated_hold_state", 32'(st0), 32'(gal_seq[6]));
    end
    en = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    check("gated_period_done", 32'(pd0), 32'h1);
    check("gated_period", 32'(per0), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
